hazard_scheduler: RTL and testbench
===================================

HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: rising-edge clock for state and counters.
REQ-002 The block SHALL have the port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-003 The block SHALL have the ports id_rs and id_rt, input, 5 bits each: source registers of the instruction in ID.
REQ-004 The block SHALL have the port id_uses_rt, input, 1 bit: ID instruction reads rt (R-type, beq, sw).
REQ-005 The block SHALL have the port id_branch, input, 1 bit: beq in ID.
REQ-006 The block SHALL have the port id_flush_req, input, 1 bit: jump or taken-branch flush request from PC decode.
REQ-007 The block SHALL have the ports ex_reg_write, ex_mem_read and ex_dst, input, 1/1/5 bits: write, load and destination of the instruction in EX.
REQ-008 The block SHALL have the ports mem_mem_read and mem_dst, input, 1/5 bits: load and destination of the instruction in MEM.
REQ-009 The block SHALL have the ports dmem_req and dmem_ready, input, 1 bit each: MEM-stage data access and memory completion handshake.
REQ-010 The block SHALL have the ports pc_write, ifid_write, idex_write and exmem_write, output, 1 bit each: pipeline register enables.
REQ-011 The block SHALL have the ports idex_bubble, memwb_bubble and ifid_flush, output, 1 bit each: bubble insertion and IF/ID flush.
REQ-012 The block SHALL have the port state, output, 2 bits: RUN=00, STALL=01, MEM_WAIT=10.
REQ-013 The block SHALL have the ports stall_count and flush_count, output, 16 bits each: saturating event counters.

Function
REQ-014 A register match SHALL be true only when the destination is nonzero and equals id_rs, or equals id_rt with id_uses_rt=1.
REQ-015 The hazard depth h SHALL be 2 for id_branch with ex_mem_read and an EX match.
REQ-016 Otherwise h SHALL be 1 for any of: ex_mem_read with an EX match; id_branch with ex_reg_write and an EX match; id_branch with mem_mem_read and a MEM match.
REQ-017 In all other cases h SHALL be 0.
REQ-018 Define mwait = dmem_req & ~dmem_ready.
REQ-019 In RUN with mwait=1, all outputs SHALL be freeze outputs and next state SHALL be MEM_WAIT.
REQ-020 Freeze outputs SHALL be: pc/ifid/idex/exmem write=0, memwb_bubble=1, idex_bubble=0, ifid_flush=0.
REQ-021 In RUN with mwait=0 and h>0, outputs SHALL be stall outputs.
REQ-022 Stall outputs SHALL be: pc_write=0, ifid_write=0, idex_bubble=1, idex/exmem write=1, memwb_bubble=0, ifid_flush=0.
REQ-023 In RUN, next state SHALL be STALL when h=2 and RUN when h=1.
REQ-024 In RUN with mwait=0 and h=0, all writes SHALL be 1, bubbles SHALL be 0, and ifid_flush SHALL equal id_flush_req.
REQ-025 In STALL, mwait=1 SHALL give freeze outputs and next state MEM_WAIT.
REQ-026 In STALL with mwait=0, outputs SHALL be stall outputs and next state SHALL be RUN, with h ignored.
REQ-027 In MEM_WAIT with dmem_ready=0, outputs SHALL be freeze outputs and state SHALL hold.
REQ-028 In MEM_WAIT with dmem_ready=1, outputs and next state SHALL be computed exactly as RUN with mwait=0 in the same cycle.
REQ-029 id_flush_req SHALL be suppressed whenever stall or freeze outputs are active; the requester re-presents it.
REQ-030 stall_count SHALL increment on every clock with pc_write=0 and saturate at 0xFFFF.
REQ-031 flush_count SHALL increment on every clock with ifid_flush=1 and saturate at 0xFFFF.

Reset
REQ-032 While reset=1, state SHALL be RUN and both counters SHALL be 0.
REQ-033 While reset=1, all write enables, bubbles and ifid_flush SHALL be 0.
REQ-034 Reset mid-STALL or mid-MEM_WAIT SHALL abandon the sequence immediately, and the first post-reset cycle SHALL evaluate as RUN.

Verification
REQ-035 Load-use: ex_mem_read=1, ex_dst=8, id_rs=8 -> one cycle with pc_write=0 and idex_bubble=1; state stays 00; stall_count=1.
REQ-036 Branch after load: id_branch=1, ex_mem_read=1, ex_dst=9, id_rt=9, id_uses_rt=1 -> 2 stall cycles (state 00 then 01 then 00); stall_count=2.
REQ-037 Zero register: ex_mem_read=1, ex_dst=0, id_rs=0 -> no stall; all writes 1.
REQ-038 Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> freeze 3 cycles in state 10, release in cycle 4; stall_count=3.
REQ-039 Flush suppression: id_flush_req=1 during a load-use stall -> ifid_flush=0; id_flush_req=1 with h=0 -> ifid_flush=1 and flush_count=1.
REQ-040 Saturation and reset: force 65536 stall cycles -> stall_count=0xFFFF; then assert reset while in MEM_WAIT -> state=00 and counters=0 asynchronously.

Source files
------------

// File: rtl/hazard_scheduler.sv
// Pipeline hazard scheduler: load-use and branch-operand stalls, data-memory wait
// freezes, IF/ID flush gating, and saturating stall/flush event counters.
module hazard_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_branch,
  input  logic        id_flush_req,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_dst,
  input  logic        mem_mem_read,
  input  logic [4:0]  mem_dst,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_write,
  output logic        exmem_write,
  output logic        idex_bubble,
  output logic        memwb_bubble,
  output logic        ifid_flush,
  output logic [1:0]  state,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    STALL    = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  state_t cur, nxt;
  logic   ex_match, mem_match, h_two, h_one, mwait;
  logic   freeze, stall;

  always_comb begin
    ex_match  = (ex_dst != 5'd0) &&
                ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));
    mem_match = (mem_dst != 5'd0) &&
                ((mem_dst == id_rs) || (id_uses_rt && (mem_dst == id_rt)));
    h_two     = id_branch && ex_mem_read && ex_match;
    h_one     = (ex_mem_read && ex_match) ||
                (id_branch && ex_reg_write && ex_match) ||
                (id_branch && mem_mem_read && mem_match);
    mwait     = dmem_req && !dmem_ready;
  end

  // MEM_WAIT releasing on dmem_ready behaves exactly like RUN with no wait;
  // the unused encoding 11 also falls through to RUN behaviour.
  always_comb begin
    nxt    = RUN;
    freeze = 1'b0;
    stall  = 1'b0;
    if ((cur == MEM_WAIT) ? !dmem_ready : mwait) begin
      freeze = 1'b1;
      nxt    = MEM_WAIT;
    end else if (cur == STALL) begin
      stall = 1'b1;
      nxt   = RUN;
    end else if (h_two || h_one) begin
      stall = 1'b1;
      nxt   = h_two ? STALL : RUN;
    end
  end

  // Every enable and bubble is forced low while reset is held.
  assign pc_write     = !reset && !freeze && !stall;
  assign ifid_write   = !reset && !freeze && !stall;
  assign idex_write   = !reset && !freeze;
  assign exmem_write  = !reset && !freeze;
  assign idex_bubble  = !reset && stall;
  assign memwb_bubble = !reset && freeze;
  assign ifid_flush   = !reset && !freeze && !stall && id_flush_req;
  assign state        = cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur         <= RUN;
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      cur <= nxt;
      if (!pc_write && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
      if (ifid_flush && (flush_count != 16'hFFFF))
        flush_count <= flush_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Scoreboard bench for hazard_scheduler: a reference model predicts each cycle,
// expectations are queued at drive time and popped when the outputs are sampled.
module tb_hazard_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_dst, mem_dst;
  logic        id_uses_rt, id_branch, id_flush_req;
  logic        ex_reg_write, ex_mem_read, mem_mem_read;
  logic        dmem_req, dmem_ready;
  logic        pc_write, ifid_write, idex_write, exmem_write;
  logic        idex_bubble, memwb_bubble, ifid_flush;
  logic [1:0]  state;
  logic [15:0] stall_count, flush_count;

  hazard_scheduler dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .id_flush_req(id_flush_req),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
    .mem_mem_read(mem_mem_read), .mem_dst(mem_dst),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .idex_bubble(idex_bubble),
    .memwb_bubble(memwb_bubble), .ifid_flush(ifid_flush), .state(state),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  st;
    logic [6:0]  ctl;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [1:0]  m_state;
  logic [15:0] m_sc, m_fc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [6:0] ctl_now();
    return {pc_write, ifid_write, idex_write, exmem_write,
            idex_bubble, memwb_bubble, ifid_flush};
  endfunction

  // Reference model: ctl = {pc, ifid, idex, exmem, idex_bubble, memwb_bubble, ifid_flush}
  task automatic predict(output logic [6:0] ctl, output logic [1:0] nxt);
    logic em, mm;
    int   h;
    em = (ex_dst != 0) && (ex_dst == id_rs || (id_uses_rt && ex_dst == id_rt));
    mm = (mem_dst != 0) && (mem_dst == id_rs || (id_uses_rt && mem_dst == id_rt));
    if (id_branch && ex_mem_read && em) h = 2;
    else if ((ex_mem_read && em) || (id_branch && ex_reg_write && em) ||
             (id_branch && mem_mem_read && mm)) h = 1;
    else h = 0;
    if ((m_state == 2'b10 && !dmem_ready) || (m_state != 2'b10 && dmem_req && !dmem_ready)) begin
      ctl = 7'b0000010; nxt = 2'b10;
    end else if (m_state == 2'b01) begin
      ctl = 7'b0011100; nxt = 2'b00;
    end else if (h > 0) begin
      ctl = 7'b0011100; nxt = (h == 2) ? 2'b01 : 2'b00;
    end else begin
      ctl = {6'b111100, id_flush_req}; nxt = 2'b00;
    end
  endtask

  // Called just after a rising edge with inputs already set.
  task automatic cycle();
    exp_t       e, g;
    logic [1:0] nxt;
    predict(e.ctl, nxt);
    e.st = m_state; e.sc = m_sc; e.fc = m_fc;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    check("state", {30'd0, state}, {30'd0, g.st});
    check("ctrl", {25'd0, ctl_now()}, {25'd0, g.ctl});
    check("stall_count", {16'd0, stall_count}, {16'd0, g.sc});
    check("flush_count", {16'd0, flush_count}, {16'd0, g.fc});
    @(posedge clk); #1;
    m_state = nxt;
    if (!g.ctl[6] && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
    if (g.ctl[0] && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; id_branch = 0; id_flush_req = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_dst = 0;
    mem_mem_read = 0; mem_dst = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  // Asynchronous reset: checked before any clock edge, released after one edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_ctrl", {25'd0, ctl_now()}, 32'd0);
    check("rst_stall_count", {16'd0, stall_count}, 32'd0);
    check("rst_flush_count", {16'd0, flush_count}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_state = 2'b00; m_sc = 0; m_fc = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    m_state = 0; m_sc = 0; m_fc = 0;
    @(posedge clk); #1;
    do_reset();
    cycle();

    // Load-use: single stall cycle, stays in RUN
    ex_mem_read = 1; ex_dst = 8; id_rs = 8;
    cycle();
    clear_inputs(); cycle();

    // Branch after load: two stall cycles via STALL
    id_branch = 1; ex_mem_read = 1; ex_dst = 9; id_rt = 9; id_uses_rt = 1;
    cycle(); cycle();
    clear_inputs(); cycle();

    // Zero destination never matches
    ex_mem_read = 1; ex_dst = 0; id_rs = 0;
    cycle();

    // Branch dependences with depth 1
    clear_inputs(); id_branch = 1; ex_reg_write = 1; ex_dst = 4; id_rs = 4; cycle();
    clear_inputs(); id_branch = 1; mem_mem_read = 1; mem_dst = 6; id_rt = 6; id_uses_rt = 1; cycle();
    clear_inputs(); mem_mem_read = 1; mem_dst = 6; id_rs = 6; cycle();
    clear_inputs(); ex_mem_read = 1; ex_dst = 7; id_rt = 7; id_uses_rt = 0; cycle();

    // Memory wait: three frozen cycles then release
    clear_inputs(); dmem_req = 1; dmem_ready = 0;
    cycle(); cycle(); cycle();
    dmem_ready = 1; cycle();
    clear_inputs(); cycle();

    // Flush suppressed during stall, passed through otherwise
    id_flush_req = 1; ex_mem_read = 1; ex_dst = 8; id_rs = 8; cycle();
    clear_inputs(); id_flush_req = 1; cycle();
    clear_inputs(); cycle();

    // Reset in the middle of STALL
    id_branch = 1; ex_mem_read = 1; ex_dst = 3; id_rs = 3;
    cycle();
    clear_inputs();
    do_reset();
    cycle();

    // Random traffic over a small register range to provoke matches
    for (int i = 0; i < 400; i++) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom); id_branch = 1'($urandom); id_flush_req = 1'($urandom);
      ex_reg_write = 1'($urandom); ex_mem_read = 1'($urandom);
      ex_dst = 5'($urandom_range(0, 3));
      mem_mem_read = 1'($urandom); mem_dst = 5'($urandom_range(0, 3));
      dmem_req = ($urandom_range(0, 3) == 0); dmem_ready = 1'($urandom);
      cycle();
    end

    // Saturation: 65536 frozen cycles, then reset while in MEM_WAIT
    clear_inputs(); do_reset();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 65536; i++) cycle();
    check("sat_stall_count", {16'd0, stall_count}, 32'h0000FFFF);
    check("sat_state", {30'd0, state}, 32'd2);
    clear_inputs();
    do_reset();
    cycle();

    if (sb.size() != 0) check("scoreboard_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
